// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: a Moore FSM that sequences each instruction through a shared memory and ALU.
// Latency: 3-5 cycles per instruction plus memory wait cycles. Outputs decode from the current state.
// Backpressure: FETCH/MEMRD/MEMWR stall while mem_ready=0. An optional timeout traps the FSM to HALT.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset (all outputs forced to 0)
//   op              IR opcode field, sampled in DECODE (and MEMADR, while the IR is held)
//   mem_ready       memory completes the current access this cycle
//   mem_req..aluop  datapath controls (see the state decode below)
//   illegal,bus_err sticky trap flags, cleared only by reset
// Optional: define MC_MAINDEC_IMMLOGIC_EN to decode ANDI/ORI through the IMMEX state.

module mc_maindec #(
    parameter int OP_W     = 6,
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            iord,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            branch,
    output logic            memwrite,
    output logic            regwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [1:0]      aluop,
    output logic            illegal,
    output logic            bus_err
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MC_MAINDEC_IMMLOGIC_EN
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
`endif

    // Counter value at which the current wait cycle becomes the MAX_WAIT-th one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
`ifdef MC_MAINDEC_IMMLOGIC_EN
        IMMEX   = 4'd12,
`endif
        HALT    = 4'd15
    } state_t;

    state_t            state, state_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n, wcnt_inc;
    logic              timeout;
    logic              set_ill, set_be;

    logic       d_mem_req, d_iord, d_irwrite, d_pcwrite, d_branch, d_memwrite;
    logic       d_regwrite, d_regdst, d_memtoreg, d_alusrca;
    logic [1:0] d_alusrcb, d_pcsrc, d_aluop;

    // Only meaningful inside a mem_req state; mem_ready on the same cycle wins.
    assign timeout  = (MAX_WAIT != 0) && !mem_ready && (wcnt == WAIT_LAST);
    // Saturate so an unbounded wait (MAX_WAIT=0) never wraps.
    assign wcnt_inc = (wcnt == '1) ? wcnt : wcnt + WAIT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            wcnt    <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (set_ill) illegal <= 1'b1;
            if (set_be)  bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        wcnt_n     = '0;
        set_ill    = 1'b0;
        set_be     = 1'b0;
        d_mem_req  = 1'b0;
        d_iord     = 1'b0;
        d_irwrite  = 1'b0;
        d_pcwrite  = 1'b0;
        d_branch   = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_regdst   = 1'b0;
        d_memtoreg = 1'b0;
        d_alusrca  = 1'b0;
        d_alusrcb  = 2'b00;
        d_pcsrc    = 2'b00;
        d_aluop    = 2'b00;

        case (state)
            FETCH: begin
                d_mem_req = 1'b1;
                d_alusrcb = 2'b01;
                if (timeout) begin
                    set_be  = 1'b1;
                    state_n = HALT;
                end else if (mem_ready) begin
                    d_irwrite = 1'b1;
                    d_pcwrite = 1'b1;
                    state_n   = DECODE;
                end else begin
                    wcnt_n = wcnt_inc;
                end
            end
            DECODE: begin
                d_alusrcb = 2'b11;
                case (op)
                    OP_RTYPE:      state_n = EXECUTE;
                    OP_LW, OP_SW:  state_n = MEMADR;
                    OP_BEQ:        state_n = BRANCH;
                    OP_ADDI:       state_n = ADDIEX;
                    OP_J:          state_n = JUMP;
`ifdef MC_MAINDEC_IMMLOGIC_EN
                    OP_ANDI, OP_ORI: state_n = IMMEX;
`endif
                    default: begin
                        set_ill = 1'b1;
                        state_n = HALT;
                    end
                endcase
            end
            MEMADR: begin
                d_alusrca = 1'b1;
                d_alusrcb = 2'b10;
                state_n   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                d_mem_req = 1'b1;
                d_iord    = 1'b1;
                if (timeout) begin
                    set_be  = 1'b1;
                    state_n = HALT;
                end else if (mem_ready) begin
                    state_n = MEMWB;
                end else begin
                    wcnt_n = wcnt_inc;
                end
            end
            MEMWB: begin
                d_regwrite = 1'b1;
                d_memtoreg = 1'b1;
                state_n    = FETCH;
            end
            MEMWR: begin
                d_mem_req = 1'b1;
                d_iord    = 1'b1;
                if (timeout) begin
                    set_be  = 1'b1;
                    state_n = HALT;
                end else if (mem_ready) begin
                    d_memwrite = 1'b1;
                    state_n    = FETCH;
                end else begin
                    wcnt_n = wcnt_inc;
                end
            end
            EXECUTE: begin
                d_alusrca = 1'b1;
                d_aluop   = 2'b10;
                state_n   = ALUWB;
            end
            ALUWB: begin
                d_regwrite = 1'b1;
                d_regdst   = 1'b1;
                state_n    = FETCH;
            end
            BRANCH: begin
                d_alusrca = 1'b1;
                d_aluop   = 2'b01;
                d_branch  = 1'b1;
                d_pcsrc   = 2'b01;
                state_n   = FETCH;
            end
            ADDIEX: begin
                d_alusrca = 1'b1;
                d_alusrcb = 2'b10;
                state_n   = IMMWB;
            end
`ifdef MC_MAINDEC_IMMLOGIC_EN
            IMMEX: begin
                d_alusrca = 1'b1;
                d_alusrcb = 2'b10;
                d_aluop   = 2'b11;
                state_n   = IMMWB;
            end
`endif
            IMMWB: begin
                d_regwrite = 1'b1;
                state_n    = FETCH;
            end
            JUMP: begin
                d_pcwrite = 1'b1;
                d_pcsrc   = 2'b10;
                state_n   = FETCH;
            end
            HALT:    state_n = HALT;
            default: state_n = HALT;
        endcase
    end

    // Reset masks the decode so no strobe (e.g. a half-finished store) leaks out while it is held.
    always_comb begin
        mem_req  = d_mem_req  & ~reset;
        iord     = d_iord     & ~reset;
        irwrite  = d_irwrite  & ~reset;
        pcwrite  = d_pcwrite  & ~reset;
        branch   = d_branch   & ~reset;
        memwrite = d_memwrite & ~reset;
        regwrite = d_regwrite & ~reset;
        regdst   = d_regdst   & ~reset;
        memtoreg = d_memtoreg & ~reset;
        alusrca  = d_alusrca  & ~reset;
        alusrcb  = reset ? 2'b00 : d_alusrcb;
        pcsrc    = reset ? 2'b00 : d_pcsrc;
        aluop    = reset ? 2'b00 : d_aluop;
    end

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec with MAX_WAIT=4.
// One step per clock: drive mem_ready after the falling edge, compare all outputs 1ns later.
// The output vector order is mem_req iord irwrite pcwrite branch memwrite regwrite regdst memtoreg alusrca _ alusrcb _ pcsrc _ aluop _ illegal bus_err.

module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, iord, irwrite, pcwrite, branch, memwrite;
    logic       regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal, bus_err;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    mc_maindec #(.OP_W(6), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {mem_req, iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst,
                  memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal, bus_err};

    localparam logic [17:0] V_ZERO   = 18'b0000000000_00_00_00_00;
    localparam logic [17:0] V_FW     = 18'b1000000000_01_00_00_00;
    localparam logic [17:0] V_FR     = 18'b1011000000_01_00_00_00;
    localparam logic [17:0] V_DEC    = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] V_MADR   = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] V_MRD    = 18'b1100000000_00_00_00_00;
    localparam logic [17:0] V_MWB    = 18'b0000001010_00_00_00_00;
    localparam logic [17:0] V_MWRW   = 18'b1100000000_00_00_00_00;
    localparam logic [17:0] V_MWRR   = 18'b1100010000_00_00_00_00;
    localparam logic [17:0] V_EXE    = 18'b0000000001_00_00_10_00;
    localparam logic [17:0] V_AWB    = 18'b0000001100_00_00_00_00;
    localparam logic [17:0] V_BR     = 18'b0000100001_00_01_01_00;
    localparam logic [17:0] V_ADDI   = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] V_IWB    = 18'b0000001000_00_00_00_00;
    localparam logic [17:0] V_JMP    = 18'b0001000000_00_10_00_00;
    localparam logic [17:0] V_HILL   = 18'b0000000000_00_00_00_10;
    localparam logic [17:0] V_HBE    = 18'b0000000000_00_00_00_01;
`ifdef MC_MAINDEC_IMMLOGIC_EN
    localparam logic [17:0] V_IMMEX  = 18'b0000000001_10_00_11_00;
`endif

    task automatic chk(input string tag, input logic [17:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; leaves the bench at the next falling edge.
    task automatic step(input logic r, input logic [17:0] exp, input string tag);
        mem_ready = r;
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear with no clock edge in between.
    task automatic do_reset(input logic r, input string tag);
        mem_ready = r;
        reset = 1'b1;
        #1;
        chk(tag, V_ZERO);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000000;
        @(negedge clk);
        #1;
        chk("reset_state", V_ZERO);
        @(negedge clk);
        reset = 1'b0;

        // R-type, ready tied high: 4 cycles
        op = 6'b000000;
        step(1'b1, V_FR,  "r_fetch");
        step(1'b1, V_DEC, "r_decode");
        step(1'b1, V_EXE, "r_execute");
        step(1'b1, V_AWB, "r_aluwb");

        // LW: 3 wait cycles in FETCH, 2 in MEMRD -> 10 cycles
        op = 6'b100011;
        for (int i = 0; i < 3; i++) step(1'b0, V_FW, "lw_fetch_wait");
        step(1'b1, V_FR,   "lw_fetch_rdy");
        step(1'b1, V_DEC,  "lw_decode");
        step(1'b1, V_MADR, "lw_memadr");
        step(1'b0, V_MRD,  "lw_memrd_wait");
        step(1'b0, V_MRD,  "lw_memrd_wait");
        step(1'b1, V_MRD,  "lw_memrd_rdy");
        step(1'b1, V_MWB,  "lw_memwb");

        // SW: memwrite only with mem_ready in MEMWR
        op = 6'b101011;
        step(1'b1, V_FR,   "sw_fetch");
        step(1'b1, V_DEC,  "sw_decode");
        step(1'b1, V_MADR, "sw_memadr");
        step(1'b0, V_MWRW, "sw_memwr_wait");
        step(1'b1, V_MWRR, "sw_memwr_rdy");

        // BEQ then J; mem_ready ignored outside memory states
        op = 6'b000100;
        step(1'b1, V_FR,  "beq_fetch");
        step(1'b0, V_DEC, "beq_decode");
        step(1'b0, V_BR,  "beq_branch");
        op = 6'b000010;
        step(1'b1, V_FR,  "j_fetch");
        step(1'b1, V_DEC, "j_decode");
        step(1'b0, V_JMP, "j_jump");

        // ADDI
        op = 6'b001000;
        step(1'b1, V_FR,   "addi_fetch");
        step(1'b1, V_DEC,  "addi_decode");
        step(1'b1, V_ADDI, "addi_exec");
        step(1'b1, V_IWB,  "addi_immwb");

        // ANDI: legal only with the immediate-logic option
        op = 6'b001100;
        step(1'b1, V_FR,  "andi_fetch");
        step(1'b1, V_DEC, "andi_decode");
`ifdef MC_MAINDEC_IMMLOGIC_EN
        step(1'b1, V_IMMEX, "andi_immex");
        step(1'b1, V_IWB,   "andi_immwb");
`else
        step(1'b1, V_HILL, "andi_illegal");
        do_reset(1'b1, "andi_reset");
`endif

        // Illegal opcode: trap, 20 quiet cycles, then reset
        op = 6'b111111;
        step(1'b1, V_FR,  "ill_fetch");
        step(1'b1, V_DEC, "ill_decode");
        for (int i = 0; i < 20; i++) step(i[0], V_HILL, "ill_halt");
        do_reset(1'b1, "ill_reset");
        op = 6'b000000;
        step(1'b1, V_FR,  "ill_after_fetch");
        step(1'b1, V_DEC, "ill_after_decode");
        step(1'b1, V_EXE, "ill_after_exec");
        step(1'b1, V_AWB, "ill_after_aluwb");

        // Timeout in FETCH after 4 wait cycles
        for (int i = 0; i < 4; i++) step(1'b0, V_FW, "to_fetch_wait");
        for (int i = 0; i < 3; i++) step(1'b1, V_HBE, "to_halt");
        do_reset(1'b0, "to_reset");

        // Ready on the 4th cycle wins over the timeout
        op = 6'b000000;
        for (int i = 0; i < 3; i++) step(1'b0, V_FW, "rdy4_fetch_wait");
        step(1'b1, V_FR,  "rdy4_fetch_rdy");
        step(1'b1, V_DEC, "rdy4_decode");
        step(1'b1, V_EXE, "rdy4_exec");
        step(1'b1, V_AWB, "rdy4_aluwb");

        // Timeout in MEMRD
        op = 6'b100011;
        step(1'b1, V_FR,   "tord_fetch");
        step(1'b1, V_DEC,  "tord_decode");
        step(1'b1, V_MADR, "tord_memadr");
        for (int i = 0; i < 4; i++) step(1'b0, V_MRD, "tord_wait");
        step(1'b1, V_HBE, "tord_halt");
        do_reset(1'b0, "tord_reset");

        // Reset in MEMWR while mem_ready is high: no store strobe
        op = 6'b101011;
        step(1'b1, V_FR,   "rstwr_fetch");
        step(1'b1, V_DEC,  "rstwr_decode");
        step(1'b1, V_MADR, "rstwr_memadr");
        do_reset(1'b1, "rstwr_midwrite");
        step(1'b0, V_FW, "rstwr_after");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore FSM that sequences MIPS instructions over several cycles through a shared memory and ALU.
- Adds a memory ready handshake with variable latency, an optional timeout and an illegal-opcode trap.
- Sits between the instruction register opcode field and the multicycle datapath; feeds the ALU decoder via aluop.

Parameters:
- OP_W, 6, opcode width.
- MAX_WAIT, 0, maximum memory wait cycles before bus_err; 0 means wait forever.
- WAIT_W, 8, width of the wait counter; requires MAX_WAIT < 2**WAIT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately.
- op  in  OP_W  opcode from the instruction register; sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMRD, MEMWR).
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load the instruction register.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write when zero.
- memwrite  out  1  store strobe.
- regwrite  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = data register, 0 = ALUOut.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  out  2  00 = add, 01 = sub, 10 = funct, 11 = imm-logic.
- illegal  out  1  sticky: unknown opcode decoded.
- bus_err  out  1  sticky: memory wait timeout.

Behaviour:
- Reset: state FETCH, wait counter 0, every output 0, including illegal and bus_err.
- Outputs are decoded from state only, except irwrite, pcwrite and memwrite. Those are gated by mem_ready in their states: the write commits on the cycle mem_ready=1.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - While mem_ready=0, hold state.
  - When mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - other -> set illegal, enter HALT.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for LW, MEMWR for SW.
  - op is held stable by the IR because irwrite=0.
- MEMRD: mem_req=1, iord=1; hold until mem_ready=1, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
- MEMWR: mem_req=1, iord=1; memwrite=mem_ready. When mem_ready=1, go to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10, then ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
- JUMP: pcwrite=1, pcsrc=10, then FETCH.
- HALT: all strobes 0; stays in HALT until reset.
- Wait counter:
  - Clears on entry to any mem_req state and on mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT with mem_ready still 0: set bus_err, enter HALT next cycle, no strobe issued.
  - mem_ready in the same cycle the counter reaches MAX_WAIT wins; no error.
- mem_ready is ignored in non-mem_req states.
- Reset asserted mid-instruction returns the FSM to FETCH with no partial writes.

Optional Feature:
- Macro: MC_MAINDEC_IMMLOGIC_EN.
- Defined: DECODE also accepts op 001100 (ANDI) and 001101 (ORI) -> IMMEX.
  - IMMEX: alusrca=1, alusrcb=10, aluop=11, then IMMWB.
  - The ALU decoder uses op[1:0] to pick AND or OR.
- Undefined: these opcodes raise illegal and enter HALT; the IMMEX state does not exist.

Test Plan:
- R-type, op=000000, mem_ready tied 1 -> FETCH, DECODE, EXECUTE, ALUWB: 4 cycles. regwrite=1 and regdst=1 only in ALUWB; aluop=10 in EXECUTE.
- LW, op=100011, mem_ready low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total. irwrite pulses exactly once, on the ready cycle. MEMWB has memtoreg=1 and regwrite=1.
- SW, op=101011 -> memwrite high for exactly 1 cycle, coincident with mem_ready in MEMWR. regwrite never asserts.
- BEQ then J -> BRANCH shows branch=1, aluop=01, pcsrc=01 (3 cycles). JUMP shows pcwrite=1, pcsrc=10 (3 cycles).
- Illegal, op=111111 -> illegal=1 one cycle after DECODE. Strobes remain 0 for 20 cycles; after a reset pulse, illegal=0 and state is FETCH.
- MAX_WAIT=4, mem_ready held 0 in FETCH -> bus_err=1 after 4 wait cycles, then HALT. Repeat with mem_ready=1 on the 4th cycle -> no error, DECODE follows.
